// File: rtl/lcd_overlay_engine.sv
// lcd_overlay_engine: parallel-RGB panel timing with background plus prioritised rectangle overlay, programmed over a byte port
module lcd_overlay_engine #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP = 2,
  parameter int H_SYNC = 41,
  parameter int H_BP = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP = 2,
  parameter int V_SYNC = 10,
  parameter int V_BP = 2,
  parameter int CLK_DIV = 4,
  parameter int NUM_RECT = 4,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] fpga_port_in,
  input  logic       fpga_rsel,
  input  logic       fpga_write,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic       DEN,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DISP_CLK,
  output logic       DISP_EN,
  output logic       led_1,
  output logic       led_2
);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HL = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VL = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int PW = $clog2(CLK_DIV);

  typedef struct packed {
    logic [9:0]  x0;
    logic [9:0]  y0;
    logic [9:0]  x1;
    logic [9:0]  y1;
    logic [23:0] col;
    logic        en;
  } rect_t;

  logic [9:0] sy1, sy2;
  logic wr_d, wr_evt, rs, set_c, commit, tick, enable, pending, s_tp, a_tp, den_c;
  logic [7:0] d, addr;
  logic [PW-1:0] phase, phase_n;
  logic [9:0] x, y;
  logic [23:0] s_bg, a_bg, col;
  logic [2:0] bar;
  rect_t s_rect [NUM_RECT];
  rect_t a_rect [NUM_RECT];

  assign wr_evt = sy2[9] & ~wr_d;
  assign rs = sy2[8];
  assign d = sy2[7:0];
  assign set_c = wr_evt && rs && addr == 8'h00 && d[7];
  assign tick = phase == '0;
  assign phase_n = phase == PW'(CLK_DIV - 1) ? '0 : phase + PW'(1);
  assign commit = tick && x == '0 && y == VA;
  assign den_c = enable && x < HA && y < VA;
  assign DISP_EN = enable;
  assign led_2 = pending;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sy1 <= '0;
      sy2 <= '0;
      wr_d <= 1'b0;
    end else begin
      sy1 <= {fpga_write, fpga_rsel, fpga_port_in};
      sy2 <= sy1;
      wr_d <= sy2[9];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr <= '0;
      enable <= 1'b0;
      pending <= 1'b0;
      s_tp <= 1'b0;
      a_tp <= 1'b0;
      s_bg <= '0;
      a_bg <= '0;
      led_1 <= 1'b0;
      for (int i = 0; i < NUM_RECT; i++) begin
        s_rect[i] <= '0;
        a_rect[i] <= '0;
      end
    end else begin
      if (commit) begin
        led_1 <= ~led_1;
        if (pending) begin
          a_tp <= s_tp;
          a_bg <= s_bg;
          a_rect <= s_rect;
        end
      end
      pending <= commit ? set_c : pending | set_c;
      if (wr_evt && !rs) addr <= d;
      if (wr_evt && rs) begin
        addr <= addr + 8'd1;
        if (addr == 8'h00) begin
          enable <= d[0];
          s_tp <= d[1];
        end
        if (addr == 8'h01) s_bg[23:16] <= d;
        if (addr == 8'h02) s_bg[15:8] <= d;
        if (addr == 8'h03) s_bg[7:0] <= d;
        for (int i = 0; i < NUM_RECT; i++)
          if (addr[7:4] == 4'(i + 1))
            case (addr[3:0])
              4'd0: s_rect[i].x0[7:0] <= d;
              4'd1: s_rect[i].x0[9:8] <= d[1:0];
              4'd2: s_rect[i].y0[7:0] <= d;
              4'd3: s_rect[i].y0[9:8] <= d[1:0];
              4'd4: s_rect[i].x1[7:0] <= d;
              4'd5: s_rect[i].x1[9:8] <= d[1:0];
              4'd6: s_rect[i].y1[7:0] <= d;
              4'd7: s_rect[i].y1[9:8] <= d[1:0];
              4'd8: s_rect[i].col[23:16] <= d;
              4'd9: s_rect[i].col[15:8] <= d;
              4'd10: s_rect[i].col[7:0] <= d;
              4'd11: s_rect[i].en <= d[0];
              default: ;
            endcase
      end
    end
  end

  always_comb begin
    col = a_bg;
    for (int i = NUM_RECT - 1; i >= 0; i--)
      if (a_rect[i].en && x >= a_rect[i].x0 && x <= a_rect[i].x1 && y >= a_rect[i].y0 && y <= a_rect[i].y1)
        col = a_rect[i].col;
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (x >= 10'(k * (H_ACTIVE / 8))) bar = 3'(k);
    col = a_tp ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : col;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      phase <= '0;
      DISP_CLK <= 1'b0;
      x <= '0;
      y <= '0;
      {R, G, B} <= '0;
      DEN <= 1'b0;
      HSYNC <= SYNC_ACTIVE_LOW;
      VSYNC <= SYNC_ACTIVE_LOW;
    end else begin
      phase <= phase_n;
      DISP_CLK <= phase_n >= PW'(CLK_DIV / 2);
      if (tick) begin
        x <= x == HL ? '0 : x + 10'd1;
        y <= x == HL ? (y == VL ? '0 : y + 10'd1) : y;
        {R, G, B} <= den_c ? col : '0;
        DEN <= den_c;
        HSYNC <= (x >= HS0 && x < HS1) ^ SYNC_ACTIVE_LOW;
        VSYNC <= (y >= VS0 && y < VS1) ^ SYNC_ACTIVE_LOW;
      end
    end
  end
endmodule

// File: tb/tb_lcd_overlay_engine.sv
// tb_lcd_overlay_engine: directed checks of timing, register bank, commit and overlay on a reduced panel geometry
module tb_lcd_overlay_engine;
  localparam int HA = 40, HFP = 2, HSY = 3, HBP = 1;
  localparam int VA = 32, VFP = 1, VSY = 2, VBP = 1;
  localparam int CD = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FR = HT * VT;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] fpga_port_in = '0;
  logic fpga_rsel = 1'b0;
  logic fpga_write = 1'b0;
  logic [7:0] R, G, B;
  logic DEN, HSYNC, VSYNC, DISP_CLK, DISP_EN, led_1, led_2;
  int n = 0;
  int vectors = 0;
  int miscompares = 0;

  lcd_overlay_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CLK_DIV(CD), .NUM_RECT(4), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .fpga_port_in(fpga_port_in), .fpga_rsel(fpga_rsel),
    .fpga_write(fpga_write), .R(R), .G(G), .B(B), .DEN(DEN), .HSYNC(HSYNC),
    .VSYNC(VSYNC), .DISP_CLK(DISP_CLK), .DISP_EN(DISP_EN), .led_1(led_1), .led_2(led_2)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) n <= Reset ? 0 : n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic goto_px(input int px, input int py);
    bit found = 0;
    for (int i = 0; i < 2 * CD * FR + 2 * CD && !found; i++) begin
      @(negedge Clk);
      found = n >= 1 && (n - 1) % CD == CD - 1 && ((n - 1) / CD) % FR == py * HT + px;
    end
    check($sformatf("reach_%0d_%0d", px, py), 32'(found), 1);
  endtask

  task automatic next_tick();
    repeat (CD) @(negedge Clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] dv, input int hold = 3);
    fpga_port_in = dv;
    fpga_rsel = rs;
    fpga_write = 1'b1;
    repeat (hold) @(negedge Clk);
    fpga_write = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic wr_rect(input logic [7:0] base, input logic [9:0] x0, input logic [9:0] y0,
                         input logic [9:0] x1, input logic [9:0] y1, input logic [23:0] c);
    wr(0, base);
    wr(1, x0[7:0]); wr(1, {6'd0, x0[9:8]});
    wr(1, y0[7:0]); wr(1, {6'd0, y0[9:8]});
    wr(1, x1[7:0]); wr(1, {6'd0, x1[9:8]});
    wr(1, y1[7:0]); wr(1, {6'd0, y1[9:8]});
    wr(1, c[23:16]); wr(1, c[15:8]); wr(1, c[7:0]);
    wr(1, 8'h01);
  endtask

  task automatic collide(input logic [7:0] dv);
    bit found = 0;
    for (int i = 0; i < 2 * CD * FR + 8 && !found; i++) begin
      @(negedge Clk);
      found = n >= 1 && (n - 1) % (CD * FR) == CD * VA * HT - 3;
    end
    check("collide_reach", 32'(found), 1);
    wr(1, dv);
  endtask

  initial begin
    int den_cnt, den_l0, hs_l0, nz, hf1, hf2, vf1, vf2, red, grn;
    logic hp, vp;
    repeat (4) @(negedge Clk);
    check("rst_rgb", {R, G, B}, 0);
    check("rst_ctl", {DEN, HSYNC, VSYNC, DISP_CLK, DISP_EN, led_1, led_2}, 7'b0110000);
    Reset = 1'b0;
    wr(0, 8'h00); wr(1, 8'h01);
    check("disp_en", DISP_EN, 1);
    wr(0, 8'h01); wr(1, 8'h00); wr(1, 8'h00); wr(1, 8'h30);
    goto_px(0, 0);
    den_cnt = 0; den_l0 = 0; hs_l0 = 0; nz = 0; hf1 = -1; hf2 = -1; vf1 = -1; vf2 = -1;
    hp = 1'b1; vp = 1'b1;
    for (int t = 0; t < 2 * FR; t++) begin
      den_cnt += int'(DEN);
      if (t < HT) begin
        den_l0 += int'(DEN);
        hs_l0 += int'(!HSYNC);
      end
      if ({R, G, B} != 24'h0) nz++;
      if (hp && !HSYNC) begin
        if (hf1 < 0) hf1 = t;
        else if (hf2 < 0) hf2 = t;
      end
      if (vp && !VSYNC) begin
        if (vf1 < 0) vf1 = t;
        else if (vf2 < 0) vf2 = t;
      end
      hp = HSYNC;
      vp = VSYNC;
      next_tick();
    end
    check("den_per_line", den_l0, HA);
    check("den_two_frames", den_cnt, 2 * VA * HA);
    check("hsync_width", hs_l0, HSY);
    check("hsync_start", hf1, HA + HFP);
    check("ticks_per_line", hf2 - hf1, HT);
    check("vsync_start", vf1, (VA + VFP) * HT);
    check("ticks_per_frame", vf2 - vf1, FR);
    check("no_commit_rgb", nz, 0);
    check("no_commit_pend", led_2, 0);

    goto_px(0, 1);
    wr(0, 8'h00); wr(1, 8'h81);
    check("pend_set", led_2, 1);
    goto_px(0, VA);
    check("pend_clr", led_2, 0);
    goto_px(5, 5);
    check("bg_commit", {R, G, B}, 24'h000030);
    check("dclk_tick_lo", DISP_CLK, 0);
    @(negedge Clk);
    check("dclk_hi", DISP_CLK, 1);

    goto_px(0, 1);
    wr_rect(8'h10, 10, 10, 19, 19, 24'hFF0000);
    wr_rect(8'h20, 15, 15, 29, 29, 24'h00FF00);
    wr(0, 8'h00); wr(1, 8'h81);
    goto_px(0, VA);
    goto_px(19, 10); check("px_19_10", {R, G, B}, 24'hFF0000);
    goto_px(15, 15); check("px_15_15", {R, G, B}, 24'hFF0000);
    goto_px(20, 20); check("px_20_20", {R, G, B}, 24'h00FF00);
    goto_px(30, 30); check("px_30_30", {R, G, B}, 24'h000030);
    check("den_30_30", DEN, 1);

    goto_px(0, 1);
    wr(0, 8'h10); wr(1, 8'd25); wr(0, 8'h14); wr(1, 8'd5);
    wr(0, 8'h00); wr(1, 8'h81);
    goto_px(0, VA);
    red = 0; grn = 0;
    for (int t = 0; t < FR; t++) begin
      if (DEN && {R, G, B} == 24'hFF0000) red++;
      if (DEN && {R, G, B} == 24'h00FF00) grn++;
      next_tick();
    end
    check("inverted_rect", red, 0);
    check("rect1_area", grn, 225);

    goto_px(0, 1);
    wr(0, 8'h01); wr(1, 8'h44, 20); wr(1, 8'h55);
    wr(0, 8'hFF); wr(1, 8'h77); wr(1, 8'h81);
    check("wrap_ctrl", led_2, 1);
    goto_px(0, VA);
    goto_px(35, 5); check("hold_once", {R, G, B}, 24'h445530);

    goto_px(0, 1);
    wr(0, 8'h02); wr(1, 8'h66); wr(0, 8'h00); wr(1, 8'h81);
    collide(8'h99);
    check("collide_bg_pend", led_2, 0);
    goto_px(35, 5); check("collide_bg_old", {R, G, B}, 24'h446630);
    wr(0, 8'h00);
    collide(8'h81);
    check("collide_ctrl_pend", led_2, 1);
    goto_px(35, 5); check("collide_ctrl_hold", {R, G, B}, 24'h446630);
    goto_px(0, VA); check("pend_after", led_2, 0);
    goto_px(35, 5); check("collide_new", {R, G, B}, 24'h996630);

    goto_px(0, 1);
    wr(0, 8'h00); wr(1, 8'h83);
    goto_px(0, VA);
    goto_px(4, 15); check("bar_white", {R, G, B}, 24'hFFFFFF);
    goto_px(5, 15); check("bar_yellow", {R, G, B}, 24'hFFFF00);
    goto_px(12, 15); check("bar_cyan", {R, G, B}, 24'h00FFFF);
    goto_px(22, 15); check("bar_magenta", {R, G, B}, 24'hFF00FF);
    goto_px(27, 15); check("bar_red", {R, G, B}, 24'hFF0000);
    goto_px(32, 15); check("bar_blue", {R, G, B}, 24'h0000FF);
    goto_px(39, 15); check("bar_black", {R, G, B, DEN}, 25'h0000001);

    wr(0, 8'h00); wr(1, 8'h02);
    check("dis_en", DISP_EN, 0);
    goto_px(10, 10); check("dis_out", {R, G, B, DEN}, 25'h0);
    goto_px(HA + HFP, 10); check("dis_hsync", HSYNC, 0);

    goto_px(0, 1);
    wr(0, 8'h00); wr(1, 8'h81);
    check("pend_pre_rst", led_2, 1);
    goto_px(20, 3);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst2_rgb", {R, G, B}, 0);
    check("rst2_ctl", {DEN, HSYNC, VSYNC, DISP_CLK, DISP_EN, led_1, led_2}, 7'b0110000);
    Reset = 1'b0;
    goto_px(0, 0);
    check("rst2_dclk", DISP_CLK, 0);
    wr(0, 8'h00); wr(1, 8'h01);
    goto_px(HA - 1, 2); check("den_last", DEN, 1);
    goto_px(HA, 2); check("den_off", DEN, 0);
    goto_px(HA + HFP - 1, 2); check("hs_pre", HSYNC, 1);
    goto_px(HA + HFP, 2); check("hs_first", HSYNC, 0);
    goto_px(HA + HFP + HSY - 1, 2); check("hs_last", HSYNC, 0);
    goto_px(HA + HFP + HSY, 2); check("hs_post", HSYNC, 1);
    goto_px(10, 10); check("rst_bank_clr", {R, G, B, DEN}, 25'h0000001);
    goto_px(HT - 1, VA + VFP - 1);
    check("vs_pre", VSYNC, 1);
    check("led1_toggle", led_1, 1);
    check("pend_discard", led_2, 0);
    goto_px(0, VA + VFP); check("vs_first", VSYNC, 0);
    goto_px(0, VA + VFP + VSY); check("vs_post", VSYNC, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
